// File: rtl/counter.sv
// rtl/counter.sv - free-running up-counter with synchronous clear-to-preload and wrap flag
// Optional macro COUNTER_STICKY_OVERFLOW_EN makes the wrap flag sticky until the next clear.
module counter #(
  parameter int DATA_WIDTH = 4,
  parameter int CLEAR_VAL  = 1
) (
  input  logic                  C,
  input  logic                  CLR,
  input  logic [DATA_WIDTH-1:0] DCLR,
  output logic [DATA_WIDTH-1:0] Q,
  output logic [DATA_WIDTH-1:0] notQ,
  output logic                  overflow
);

  generate
    if (CLEAR_VAL != 1) begin : g_bad_clear_val
      $error("counter: CLEAR_VAL must be 1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
      $error("counter: DATA_WIDTH must be >= 1");
    end
  endgenerate

  // Initial values only give simulation a defined start; hardware is defined after the first clear.
  logic [DATA_WIDTH-1:0] count_q = '0;
  logic [DATA_WIDTH-1:0] count_d;
  logic                  overflow_q = 1'b0;
  logic                  overflow_d;
  logic                  wrap;

  always_comb begin
    count_d    = count_q + DATA_WIDTH'(1);
    wrap       = &count_q;
`ifdef COUNTER_STICKY_OVERFLOW_EN
    overflow_d = overflow_q | wrap;
`else
    overflow_d = wrap;
`endif
  end

  always_ff @(posedge C) begin
    if (CLR) begin
      count_q    <= DCLR;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign Q        = count_q;
  assign notQ     = ~count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - directed-vector bench for counter
// Expectations are hand-computed constants; sticky expectations follow COUNTER_STICKY_OVERFLOW_EN.
module tb_counter;

`ifdef COUNTER_STICKY_OVERFLOW_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic       c;
  logic       clr;
  logic [3:0] dclr;
  logic [3:0] q;
  logic [3:0] not_q;
  logic       overflow;

  int vectors_applied = 0;
  int miscompares     = 0;

  counter #(.DATA_WIDTH(4), .CLEAR_VAL(1)) dut (
    .C        (c),
    .CLR      (clr),
    .DCLR     (dclr),
    .Q        (q),
    .notQ     (not_q),
    .overflow (overflow)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors_applied++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge c);
    #1;
  endtask

  initial begin
    clr  = 1'b1;
    dclr = 4'h0;

    // clear load
    step();
    check("clr_q",    16'(q),        16'h0);
    check("clr_notq", 16'(not_q),    16'hF);
    check("clr_ovf",  16'(overflow), 16'h0);

    // count 1..5
    clr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("cnt_q",    16'(q),     16'(i));
      check("cnt_notq", 16'(not_q), 16'(4'hF - 4'(i)));
      check("cnt_ovf",  16'(overflow), 16'h0);
    end

    // wrap from F via preload
    clr = 1'b1; dclr = 4'hF;
    step();
    check("pre_f_q",   16'(q),        16'hF);
    check("pre_f_ovf", 16'(overflow), 16'h0);
    clr = 1'b0;
    step();
    check("wrap_q",    16'(q),        16'h0);
    check("wrap_notq", 16'(not_q),    16'hF);
    check("wrap_ovf",  16'(overflow), 16'h1);
    step();
    check("post_wrap_q",   16'(q),        16'h1);
    check("post_wrap_ovf", 16'(overflow), 16'(STICKY));

    // count to 6, then mid-count clear to 9
    for (int i = 0; i < 5; i++) step();
    check("mid_q6", 16'(q), 16'h6);
    clr = 1'b1; dclr = 4'h9;
    step();
    check("mid_clr_q",   16'(q),        16'h9);
    check("mid_clr_ovf", 16'(overflow), 16'h0);
    clr = 1'b0;
    step();
    check("mid_next_q", 16'(q), 16'hA);

    // held clear
    clr = 1'b1; dclr = 4'h3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_q", 16'(q), 16'h3);
    end
    clr = 1'b0;
    step();
    check("release_q", 16'(q), 16'h4);

    // DCLR ignored while CLR low
    dclr = 4'hC;
    step();
    check("dclr_ign_q", 16'(q), 16'h5);

    // CLR pulse between edges is not honoured
    #2 clr = 1'b1;
    #2 clr = 1'b0;
    step();
    check("glitch_q", 16'(q), 16'h6);

    // natural wrap from E, then four more edges
    clr = 1'b1; dclr = 4'hE;
    step();
    clr = 1'b0;
    step();
    check("nat_f_q",   16'(q),        16'hF);
    check("nat_f_ovf", 16'(overflow), 16'h0);
    step();
    check("nat_wrap_q",   16'(q),        16'h0);
    check("nat_wrap_ovf", 16'(overflow), 16'h1);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("after_q",   16'(q),        16'(i));
      check("after_ovf", 16'(overflow), 16'(STICKY));
    end
    clr = 1'b1; dclr = 4'h2;
    step();
    check("final_clr_q",   16'(q),        16'h2);
    check("final_clr_ovf", 16'(overflow), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
